// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared sizes and FSM state encoding for the FFT magnitude/peak block
package fft_pkg;
  localparam int N_POINT = 8;
  localparam int ADDR_W  = 3;
  localparam int DATA_W  = 24;
  localparam int MAG_W   = 2 * DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_CALC    = 3'd4,
    ST_OUT     = 3'd5,
    ST_DONE    = 3'd6
  } state_e;
endpackage

// File: rtl/fft_mag_sq.sv
// rtl/fft_mag_sq.sv - registered re^2+im^2 of one signed FFT bin, loaded when en_i is high
module fft_mag_sq
  import fft_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] re_i,
  input  logic signed [DATA_W-1:0] im_i,
  output logic        [MAG_W-1:0]  mag_o
);
  logic signed [MAG_W-1:0] re_x, im_x;
  logic signed [MAG_W-1:0] re_sq, im_sq;
  logic        [MAG_W-1:0] mag_d, mag_q;

  // Each square is at most 2^(2*DATA_W-2), so the unsigned sum never wraps.
  always_comb begin
    re_x  = {{DATA_W{re_i[DATA_W-1]}}, re_i};
    im_x  = {{DATA_W{im_i[DATA_W-1]}}, im_i};
    re_sq = re_x * re_x;
    im_sq = im_x * im_x;
    mag_d = $unsigned(re_sq) + $unsigned(im_sq);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_q <= '0;
    end else if (en_i) begin
      mag_q <= mag_d;
    end
  end

  assign mag_o = mag_q;
endmodule

// File: rtl/fft_mag_peak.sv
// rtl/fft_mag_peak.sv - sweeps FFT result RAM, streams |X|^2 per bin, reports the peak bin
// PEAK_SKIP_DC_EN: when defined, bin 0 is streamed but excluded from the peak search.
module fft_mag_peak
  import fft_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flag_fftfinish,
  output logic        [ADDR_W-1:0] read_addr,
  input  logic signed [DATA_W-1:0] dataout_re,
  input  logic signed [DATA_W-1:0] dataout_im,
  output logic                     mag_valid,
  input  logic                     mag_ready,
  output logic        [MAG_W-1:0]  mag_data,
  output logic        [ADDR_W-1:0] mag_bin,
  output logic                     mag_last,
  output logic                     peak_valid,
  output logic        [ADDR_W-1:0] peak_bin,
  output logic        [MAG_W-1:0]  peak_mag,
  output logic                     busy
);
  localparam logic [1:0]        WAIT_LAST = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;
  localparam logic [ADDR_W-1:0] LAST_BIN  = ADDR_W'(N_POINT - 1);

  state_e                   state_q, state_d;
  logic                     flag_q;
  logic        [ADDR_W-1:0] bin_q, read_addr_q, peak_bin_q;
  logic        [1:0]        wait_cnt_q;
  logic signed [DATA_W-1:0] re_q, im_q;
  logic        [MAG_W-1:0]  mag, peak_mag_q;
  logic                     peak_seen_q;
  logic                     start, beat, is_last, peak_cand;

  assign start   = flag_fftfinish && !flag_q;
  assign beat    = mag_valid && mag_ready;
  assign is_last = (bin_q == LAST_BIN);

`ifdef PEAK_SKIP_DC_EN
  assign peak_cand = (bin_q != '0);
`else
  assign peak_cand = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = ST_ISSUE;
      ST_ISSUE:         state_d = (RD_LAT == 0) ? ST_CAPTURE : ST_WAIT;
      ST_WAIT:          if (wait_cnt_q == WAIT_LAST) state_d = ST_CAPTURE;
      ST_CAPTURE:       state_d = ST_CALC;
      ST_CALC:          state_d = ST_OUT;
      ST_OUT:           if (beat) state_d = is_last ? ST_DONE : ST_ISSUE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = 1'b0;
    mag_valid  = 1'b0;
    peak_valid = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_DONE: peak_valid = 1'b1;
      ST_OUT: begin
        busy      = 1'b1;
        mag_valid = 1'b1;
      end
      default: busy = 1'b1;
    endcase
  end

  // read_addr only moves in ISSUE, so it stays put through a stalled OUT beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_q      <= 1'b0;
      bin_q       <= '0;
      read_addr_q <= '0;
      wait_cnt_q  <= '0;
      re_q        <= '0;
      im_q        <= '0;
      peak_bin_q  <= '0;
      peak_mag_q  <= '0;
      peak_seen_q <= 1'b0;
    end else begin
      flag_q <= flag_fftfinish;
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            bin_q       <= '0;
            peak_seen_q <= 1'b0;
          end
        end
        ST_ISSUE: begin
          read_addr_q <= bin_q;
          wait_cnt_q  <= '0;
        end
        ST_WAIT:    wait_cnt_q <= wait_cnt_q + 2'd1;
        ST_CAPTURE: begin
          re_q <= dataout_re;
          im_q <= dataout_im;
        end
        ST_OUT: begin
          if (beat) begin
            // Ties keep the earlier (lower) bin.
            if (peak_cand && (!peak_seen_q || mag > peak_mag_q)) begin
              peak_bin_q <= bin_q;
              peak_mag_q <= mag;
            end
            if (peak_cand) peak_seen_q <= 1'b1;
            if (!is_last) bin_q <= bin_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  fft_mag_sq u_mag_sq (
    .clk   (clk),
    .rst_n (rst),
    .en_i  (state_q == ST_CALC),
    .re_i  (re_q),
    .im_i  (im_q),
    .mag_o (mag)
  );

  assign read_addr = read_addr_q;
  assign mag_data  = mag;
  assign mag_bin   = bin_q;
  assign mag_last  = mag_valid && is_last;
  assign peak_bin  = peak_bin_q;
  assign peak_mag  = peak_mag_q;
endmodule

// File: tb/tb_fft_mag_peak.sv
// tb/tb_fft_mag_peak.sv - randomized bench for fft_mag_peak against a sweep/peak reference model
module tb_fft_mag_peak;
`ifdef PEAK_SKIP_DC_EN
  localparam bit SKIP_DC = 1'b1;
`else
  localparam bit SKIP_DC = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               flag = 1'b0;
  logic        [2:0]  read_addr;
  logic signed [23:0] dre = '0, dim = '0;
  logic               mag_valid, mag_last, peak_valid, busy;
  logic               mag_ready = 1'b1;
  logic        [47:0] mag_data, peak_mag;
  logic        [2:0]  mag_bin, peak_bin;

  int checks = 0;
  int errors = 0;

  logic signed [23:0] mem_re [8];
  logic signed [23:0] mem_im [8];
  longint exp_mag [8];
  longint got_mag [8];
  int     exp_pk_bin;
  longint exp_pk_mag;
  int     exp_idx;
  bit     mon_en = 1'b0;
  bit     rand_ready = 1'b0;
  bit     force_ready = 1'b1;
  logic        prev_stall = 1'b0;
  logic [47:0] prev_data;
  logic [2:0]  prev_bin;
  int     cyc;

  fft_mag_peak #(.RD_LAT(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .flag_fftfinish (flag),
    .read_addr      (read_addr),
    .dataout_re     (dre),
    .dataout_im     (dim),
    .mag_valid      (mag_valid),
    .mag_ready      (mag_ready),
    .mag_data       (mag_data),
    .mag_bin        (mag_bin),
    .mag_last       (mag_last),
    .peak_valid     (peak_valid),
    .peak_bin       (peak_bin),
    .peak_mag       (peak_mag),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Result RAM with one clock of read latency.
  always @(posedge clk) begin
    dre <= mem_re[read_addr];
    dim <= mem_im[read_addr];
  end

  always @(posedge clk) begin
    #1;
    mag_ready = rand_ready ? 1'($urandom_range(0, 1)) : force_ready;
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: |X|^2 per bin, then the first bin holding the strict maximum.
  task automatic build_model();
    exp_pk_bin = -1;
    exp_pk_mag = 0;
    for (int k = 0; k < 8; k++) begin
      exp_mag[k] = longint'(mem_re[k]) * longint'(mem_re[k]) + longint'(mem_im[k]) * longint'(mem_im[k]);
      got_mag[k] = -1;
      if (!(SKIP_DC && k == 0) && (exp_pk_bin < 0 || exp_mag[k] > exp_pk_mag)) begin
        exp_pk_bin = k;
        exp_pk_mag = exp_mag[k];
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall) begin
        check_eq("hold_valid", longint'(mag_valid), 1);
        check_eq("hold_data", longint'(mag_data), longint'(prev_data));
        check_eq("hold_bin", longint'(mag_bin), longint'(prev_bin));
      end
      if (mag_valid && mag_ready) begin
        check_eq("beat_bin", longint'(mag_bin), exp_idx);
        check_eq("beat_data", longint'(mag_data), exp_mag[exp_idx & 7]);
        check_eq("beat_last", longint'(mag_last), longint'(exp_idx == 7));
        got_mag[exp_idx & 7] = longint'(mag_data);
        exp_idx++;
      end
      prev_stall = mag_valid && !mag_ready;
      prev_data  = mag_data;
      prev_bin   = mag_bin;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic start_sweep();
    build_model();
    exp_idx = 0;
    mon_en  = 1'b1;
    @(negedge clk);
    flag = 1'b1;
  endtask

  task automatic finish_sweep(input bit hold, input bit glitch, output int cycles);
    cycles = 0;
    @(posedge clk);
    @(negedge clk);
    while (!peak_valid && cycles < 3000) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (!hold && cycles == 2) flag = 1'b0;
      if (glitch && cycles == 5) flag = 1'b1;
      if (glitch && cycles == 8) flag = 1'b0;
    end
    mon_en = 1'b0;
    check_eq("sweep_done", longint'(peak_valid), 1);
    check_eq("beat_count", exp_idx, 8);
    check_eq("peak_bin", longint'(peak_bin), exp_pk_bin);
    check_eq("peak_mag", longint'(peak_mag), exp_pk_mag);
    check_eq("done_busy", longint'(busy), 0);
    check_eq("done_valid", longint'(mag_valid), 0);
  endtask

  function automatic int rnd_i(input real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
  endfunction

  task automatic load_fft_vector();
    int  x [8];
    real sr, si, ang;
    x = '{1, 4, 5, 6, 7, 8, 9, 10};
    for (int k = 0; k < 8; k++) begin
      sr = 0.0;
      si = 0.0;
      for (int n = 0; n < 8; n++) begin
        ang = 2.0 * 3.14159265358979 * real'(k * n) / 8.0;
        sr  = sr + real'(x[n]) * $cos(ang);
        si  = si - real'(x[n]) * $sin(ang);
      end
      mem_re[k] = 24'(rnd_i(sr));
      mem_im[k] = 24'(rnd_i(si));
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) begin
      mem_re[k] = '0;
      mem_im[k] = '0;
    end
    repeat (3) @(negedge clk);
    check_eq("rst_busy", longint'(busy), 0);
    check_eq("rst_mag_valid", longint'(mag_valid), 0);
    check_eq("rst_peak_valid", longint'(peak_valid), 0);
    check_eq("rst_read_addr", longint'(read_addr), 0);
    check_eq("rst_peak_mag", longint'(peak_mag), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // FFT of 1,4,5,6,7,8,9,10
    load_fft_vector();
    start_sweep();
    finish_sweep(1'b0, 1'b0, cyc);
    check_eq("t1_latency", cyc, 40);
    check_eq("t1_bin0", got_mag[0], 2500);
    check_eq("t1_bin4", got_mag[4], 36);
    check_eq("t1_peak_bin", longint'(peak_bin), 0);
    check_eq("t1_peak_mag", longint'(peak_mag), 2500);

    // re=3*addr, im=-addr
    for (int k = 0; k < 8; k++) begin
      mem_re[k] = 24'(3 * k);
      mem_im[k] = 24'(-k);
    end
    start_sweep();
    finish_sweep(1'b0, 1'b0, cyc);
    check_eq("t2_bin5", got_mag[5], 250);
    check_eq("t2_peak_bin", longint'(peak_bin), 7);
    check_eq("t2_peak_mag", longint'(peak_mag), 490);

    // all bins tie at 25
    for (int k = 0; k < 8; k++) begin
      mem_re[k] = 24'sd5;
      mem_im[k] = 24'sd0;
    end
    start_sweep();
    finish_sweep(1'b0, 1'b0, cyc);
    check_eq("t3_peak_bin", longint'(peak_bin), SKIP_DC ? 1 : 0);
    check_eq("t3_peak_mag", longint'(peak_mag), 25);

    // most negative re/im at bin 2
    for (int k = 0; k < 8; k++) begin
      mem_re[k] = 24'($urandom_range(0, 200)) - 24'sd100;
      mem_im[k] = 24'($urandom_range(0, 200)) - 24'sd100;
    end
    mem_re[2] = -24'sd8388608;
    mem_im[2] = -24'sd8388608;
    start_sweep();
    finish_sweep(1'b0, 1'b0, cyc);
    check_eq("t4_bin2", got_mag[2], 64'd140737488355328);
    check_eq("t4_peak_bin", longint'(peak_bin), 2);

    // backpressure at bin 3
    for (int k = 0; k < 8; k++) begin
      mem_re[k] = 24'($urandom);
      mem_im[k] = 24'($urandom);
    end
    start_sweep();
    for (int i = 0; i < 200 && !(mag_bin == 3'd3 && !mag_valid && busy); i++) @(negedge clk);
    force_ready = 1'b0;
    for (int i = 0; i < 50 && !mag_valid; i++) @(negedge clk);
    check_eq("bp_reach", longint'(mag_valid && mag_bin == 3'd3), 1);
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_valid", longint'(mag_valid), 1);
      check_eq("bp_bin", longint'(mag_bin), 3);
      check_eq("bp_addr", longint'(read_addr), 3);
      check_eq("bp_data", longint'(mag_data), exp_mag[3]);
    end
    force_ready = 1'b1;
    finish_sweep(1'b0, 1'b0, cyc);

    // random data, random ready, flag edges while busy
    rand_ready = 1'b1;
    repeat (4) begin
      for (int k = 0; k < 8; k++) begin
        mem_re[k] = ($urandom_range(0, 3) == 0) ? -24'sd8388608 : 24'($urandom);
        mem_im[k] = 24'($urandom);
      end
      start_sweep();
      finish_sweep(1'b0, 1'b1, cyc);
    end
    rand_ready = 1'b0;

    // reset pulse during bin 4
    start_sweep();
    for (int i = 0; i < 200 && !(mag_valid && mag_bin == 3'd4); i++) @(negedge clk);
    check_eq("mid_reach", longint'(mag_valid && mag_bin == 3'd4), 1);
    mon_en = 1'b0;
    flag = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_eq("mid_busy", longint'(busy), 0);
    check_eq("mid_mag_valid", longint'(mag_valid), 0);
    check_eq("mid_mag_data", longint'(mag_data), 0);
    check_eq("mid_mag_bin", longint'(mag_bin), 0);
    check_eq("mid_read_addr", longint'(read_addr), 0);
    check_eq("mid_peak_valid", longint'(peak_valid), 0);
    check_eq("mid_peak", longint'({peak_bin, peak_mag}), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    start_sweep();
    finish_sweep(1'b0, 1'b0, cyc);
    check_eq("mid_restart_lat", cyc, 40);

    // flag held high after the sweep must not retrigger
    @(negedge clk);
    flag = 1'b0;
    for (int k = 0; k < 8; k++) mem_re[k] = 24'(k * 7);
    start_sweep();
    finish_sweep(1'b1, 1'b0, cyc);
    begin
      int busy_seen;
      busy_seen = 0;
      repeat (60) begin
        @(negedge clk);
        if (busy) busy_seen++;
      end
      check_eq("hold_no_retrigger", busy_seen, 0);
      check_eq("hold_peak_valid", longint'(peak_valid), 1);
    end
    flag = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
